// File: rtl/fc_argmax_ctrl.sv
// Streaming argmax over one frame of LAYER_SIZE signed class scores with a ready/valid result.
// Define FC_ARGMAX_VAL_EN to add the out_val port carrying the winning score itself.
module fc_argmax_ctrl #(
    parameter int WORD_SIZE  = 16,
    parameter int LAYER_SIZE = 10,
    localparam int N = $clog2(LAYER_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic signed [WORD_SIZE-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                out_idx,
    output logic                        busy
`ifdef FC_ARGMAX_VAL_EN
    ,
    output logic signed [WORD_SIZE-1:0] out_val
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [N-1:0] LAST_IDX = N'(LAYER_SIZE - 1);
    localparam logic [N-1:0] ONE_IDX  = N'(1);

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [N-1:0]                count_r;
    logic [N-1:0]                max_idx_r;
    logic signed [WORD_SIZE-1:0] max_val_r;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic                        busy_r;
    logic                        accept_s;
    logic                        take_s;

    // Next-state decode plus score-acceptance and max-replacement qualifiers.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                accept_s = in_valid;
                // Strict compare keeps the earliest index on a tie.
                if ((count_r == {N{1'b0}}) || (in_data > max_val_r)) begin
                    take_s = in_valid;
                end else begin
                    take_s = 1'b0;
                end
                if (in_valid && (count_r == LAST_IDX)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, frame counter, running maximum and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {N{1'b0}};
            max_idx_r   <= {N{1'b0}};
            max_val_r   <= {WORD_SIZE{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == COLLECT);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
            if ((state_r == IDLE) && start) begin
                count_r <= {N{1'b0}};
            end else if (accept_s) begin
                count_r <= (count_r == LAST_IDX) ? {N{1'b0}} : (count_r + ONE_IDX);
            end else begin
                count_r <= count_r;
            end
            if (take_s) begin
                max_val_r <= in_data;
                max_idx_r <= count_r;
            end else begin
                max_val_r <= max_val_r;
                max_idx_r <= max_idx_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_idx   = max_idx_r;
`ifdef FC_ARGMAX_VAL_EN
    assign out_val   = max_val_r;
`endif

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// Self-checking bench for fc_argmax_ctrl: directed frames plus random frames
// checked against an argmax computed directly over the score list.
module tb_fc_argmax_ctrl;

    localparam int W = 16;
    localparam int L = 10;
    localparam int N = $clog2(L);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [N-1:0]        out_idx;
    logic                busy;
`ifdef FC_ARGMAX_VAL_EN
    logic signed [W-1:0] out_val;
`endif

    int errors = 0;
    int checks = 0;
    int scores [L];

    fc_argmax_ctrl #(.WORD_SIZE(W), .LAYER_SIZE(L)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .busy(busy)
`ifdef FC_ARGMAX_VAL_EN
        , .out_val(out_val)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the largest value.
    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < L; i++) if (scores[i] > scores[best]) best = i;
        return best;
    endfunction

    // Open a frame and stream all scores, optionally pausing in_valid before score stall_at.
    task automatic collect(input string name, input int stall_at, input int stall_len);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s open: busy=%b in_ready=%b required 1/1", name, busy, in_ready);
        end
        for (int i = 0; i < L; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    checks++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s stall: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
                    end
                end
            end
            in_valid = 1'b1;
            in_data  = 16'(scores[i]);
            tick();
            if (i < L - 1) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s early: score %0d out_valid=%b in_ready=%b required 0/1", name, i, out_valid, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== N'(ref_argmax())) begin
            errors++;
            $display("FAIL %s result: out_valid=%b in_ready=%b out_idx=%0d required 1/0/%0d",
                     name, out_valid, in_ready, out_idx, ref_argmax());
        end
`ifdef FC_ARGMAX_VAL_EN
        checks++;
        if (out_val !== 16'(scores[ref_argmax()])) begin
            errors++;
            $display("FAIL %s out_val: got %0d required %0d", name, out_val, scores[ref_argmax()]);
        end
`endif
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: out_valid=%b busy=%b in_ready=%b required 0/0/0", name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_idx !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b in_ready=%b out_valid=%b out_idx=%0d required 0/0/0/0",
                     busy, in_ready, out_valid, out_idx);
        end
    endtask

    task automatic test_directed();
        int v [L] = '{3, -1, 7, 2, 7, 0, -5, 6, 1, 4};
        for (int i = 0; i < L; i++) scores[i] = v[i];
        collect("directed", -1, 0);
        checks++;
        if (out_idx !== N'(2)) begin
            errors++;
            $display("FAIL directed_idx: got %0d required 2", out_idx);
        end
        drain("directed");
    endtask

    task automatic test_boundary();
        for (int i = 0; i < L; i++) scores[i] = -32768;
        scores[9] = -32767;
        collect("extreme", -1, 0);
        drain("extreme");
        for (int i = 0; i < L; i++) scores[i] = 5;
        collect("all_equal", -1, 0);
        drain("all_equal");
    endtask

    task automatic test_stall();
        for (int i = 0; i < L; i++) scores[i] = int'($urandom_range(200, 0)) - 100;
        collect("stall", 4, 3);
        drain("stall");
    endtask

    task automatic test_backpressure();
        logic [N-1:0] held;
        for (int i = 0; i < L; i++) scores[i] = int'($urandom_range(65535, 0)) - 32768;
        collect("bp", -1, 0);
        held = out_idx;
        for (int c = 0; c < 5; c++) begin
            start    = c[0];
            in_valid = 1'b1;
            in_data  = 16'sh7fff;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== held) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b out_idx=%0d required 1/0/%0d",
                         out_valid, in_ready, out_idx, held);
            end
        end
        in_valid = 1'b0;
        start = 1'b1;
        drain("bp");
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_ignored: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 1) ? 16'sh7fff : 16'sd0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_idx !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b in_ready=%b out_valid=%b out_idx=%0d required 0/0/0/0",
                     busy, in_ready, out_valid, out_idx);
        end
        for (int i = 0; i < L; i++) scores[i] = int'($urandom_range(100, 0)) - 50;
        scores[8] = 1000;
        collect("abort_new", -1, 0);
        checks++;
        if (out_idx !== N'(8)) begin
            errors++;
            $display("FAIL abort_idx: got %0d required 8", out_idx);
        end
        drain("abort_new");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < L; i++) scores[i] = int'($urandom_range(15, 0)) - 8;
            collect("b2b", -1, 0);
            drain("b2b");
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < L; i++) begin
                if (f[0]) scores[i] = int'($urandom_range(7, 0)) - 4;
                else      scores[i] = int'($urandom_range(65535, 0)) - 32768;
            end
            collect("random", int'($urandom_range(L + 2, 1)), int'($urandom_range(3, 0)));
            drain("random");
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_stall();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_argmax_ctrl.md
FC_ARGMAX_CTRL -- requirements
Module: fc_argmax_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, signed score width.
REQ-002 SHALL have parameter LAYER_SIZE, default 10, number of class scores per frame (>=2).
REQ-003 SHALL define local N = $clog2(LAYER_SIZE), the index width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that opens a frame.
REQ-007 SHALL have port in_valid  input  1  score present on in_data.
REQ-008 SHALL have port in_data  input  WORD_SIZE  signed class score.
REQ-009 SHALL have port in_ready  output  1  block accepts a score this cycle.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_idx  output  N  index of maximum score.
REQ-013 SHALL have port busy  output  1  frame in progress (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> COLLECT, count:=0.
REQ-016 COLLECT: in_ready=1; a score is accepted on in_valid&&in_ready.
REQ-017 Accepted score at count==0 SHALL load max_val:=in_data, max_idx:=0.
REQ-018 Accepted score at count>0 SHALL replace max only if in_data > max_val (signed, strict); ties keep the earlier index.
REQ-019 count SHALL increment per accepted score; the score accepted at count==LAYER_SIZE-1 -> DONE next cycle, with max registers already updated by that score.
REQ-020 in_valid low in COLLECT SHALL stall with no state change; there is no timeout.
REQ-021 DONE: out_valid=1, in_ready=0, out_idx=max_idx stable until handshake.
REQ-022 out_valid&&out_ready in DONE -> IDLE next cycle; out_valid low that cycle.
REQ-023 start in COLLECT or DONE SHALL be ignored.
REQ-024 start asserted in the same cycle as the DONE handshake SHALL be ignored; a new frame needs start in IDLE.
REQ-025 Latency from the last accepted score to out_valid SHALL be exactly 1 cycle.
REQ-026 Throughput SHALL be one score per cycle.
REQ-027 Frame-to-frame gap SHALL be at least 1 IDLE cycle.
REQ-028 count SHALL be N bits wide and never exceed LAYER_SIZE-1.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, count=0, max_val=0, max_idx=0, out_valid=0, in_ready=0, busy=0.
REQ-030 Reset mid-COLLECT or in DONE SHALL discard the partial frame or the pending result.
REQ-031 rst SHALL dominate start, in_valid and out_ready in the same cycle.

Configuration
REQ-032 Macro FC_ARGMAX_VAL_EN defined: extra port out_val, output, WORD_SIZE, signed max score, valid with out_val under the same rules as out_idx and reset to 0.
REQ-033 FC_ARGMAX_VAL_EN undefined: out_val port absent; the out_idx behaviour is identical.

Verification
REQ-034 Scores 3,-1,7,2,7,0,-5,6,1,4, in_valid continuous -> out_valid on the cycle after the 10th score, out_idx=2 (tie at 4 ignored), out_val=7 if enabled.
REQ-035 All scores -32768 except index 9 = -32767 -> out_idx=9; all scores equal to 5 -> out_idx=0.
REQ-036 in_valid deasserted for 3 cycles after the 4th score, then resumed -> same result as continuous streaming, in_ready held 1 during the stall.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_valid and out_idx stable; in_ready=0; start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst pulsed after the 6th score, then a new start and frame with maximum at index 8 -> out_idx=8, with no contamination from the aborted frame.
REQ-039 Two frames with one idle cycle and start between them -> two results, each correct and each delivered by its own handshake.
